// File: rtl/perf_counter_bank_pkg.sv
// ============================================================================
// perf_counter_bank_pkg : shared register offsets and SEL layout for the bank
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef TOTAL_PERF_EVENTS
`define TOTAL_PERF_EVENTS 16
`endif

package perf_counter_bank_pkg;

   // Offsets inside one 16-byte counter slot
   localparam logic [3:0] PERF_SEL        = 4'h0;
   localparam logic [3:0] PERF_COUNT_LO   = 4'h4;
   localparam logic [3:0] PERF_COUNT_HI   = 4'h8;

   // Offsets inside the global slot that follows the last counter
   localparam logic [3:0] PERF_CTRL       = 4'h0;
   localparam logic [3:0] PERF_OVF_STATUS = 4'h4;
   localparam logic [3:0] PERF_OVF_MASK   = 4'h8;

   typedef logic [7:0] perf_event_idx_t;

   typedef struct packed {
      logic            enable;
      logic [22:0]     reserved;
      perf_event_idx_t event_idx;
   } perf_sel_t;

endpackage

`default_nettype wire

// File: rtl/perf_counter_slice.sv
// ============================================================================
// perf_counter_slice : one programmable counter with SEL, HI shadow and wrap
// Revision: 1.0
// ============================================================================
`default_nettype none

module perf_counter_slice
   import perf_counter_bank_pkg::*;
#(
   parameter int NUM_EVENTS    = 16,
   parameter int COUNTER_WIDTH = 48
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] perf_events_i,
   input  logic                  freeze_i,
   input  logic                  sel_we_i,
   input  logic                  lo_we_i,
   input  logic                  hi_we_i,
   input  logic                  lo_re_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           sel_o,
   output logic [31:0]           count_lo_o,
   output logic [31:0]           shadow_o,
   output logic                  wrap_o
);

   localparam int HW = COUNTER_WIDTH - 32;

   perf_sel_t                sel_q, sel_d;
   logic [COUNTER_WIDTH-1:0] count_q, count_d;
   logic [HW-1:0]            shadow_q, shadow_d;
   logic [255:0]             events_ext;
   logic                     hit;

   // Widening to 256 lets any 8-bit index be used safely; out-of-range ones never count
   assign events_ext = 256'(perf_events_i);
   assign hit = sel_q.enable && !freeze_i
             && ({1'b0, sel_q.event_idx} < 9'(NUM_EVENTS))
             && events_ext[sel_q.event_idx];

   always_comb begin
      sel_d    = sel_q;
      count_d  = count_q;
      wrap_o   = 1'b0;
      shadow_d = shadow_q;
      if (sel_we_i) begin
         sel_d.enable    = wdata_i[31];
         sel_d.reserved  = '0;
         sel_d.event_idx = wdata_i[7:0];
      end
      // A bus write to either half pre-empts this cycle's increment entirely
      if (lo_we_i) begin
         count_d[31:0] = wdata_i;
      end else if (hi_we_i) begin
         count_d[COUNTER_WIDTH-1:32] = wdata_i[HW-1:0];
      end else if (hit) begin
         count_d = count_q + COUNTER_WIDTH'(1);
         wrap_o  = &count_q;
      end
      if (lo_re_i) begin
         shadow_d = count_q[COUNTER_WIDTH-1:32];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sel_q    <= '0;
         count_q  <= '0;
         shadow_q <= '0;
      end else begin
         sel_q    <= sel_d;
         count_q  <= count_d;
         shadow_q <= shadow_d;
      end
   end

   assign sel_o      = sel_q;
   assign count_lo_o = count_q[31:0];
   assign shadow_o   = 32'(shadow_q);

endmodule

`default_nettype wire

// File: rtl/perf_counter_bank.sv
// ============================================================================
// perf_counter_bank : I/O-bus slave with NUM_COUNTERS programmable counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module perf_counter_bank
   import perf_counter_bank_pkg::*;
#(
   parameter int NUM_EVENTS    = `TOTAL_PERF_EVENTS,
   parameter int NUM_COUNTERS  = 4,
   parameter int COUNTER_WIDTH = 48,
   parameter int BASE_ADDRESS  = 'h130
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_EVENTS-1:0] perf_events,
   input  logic                  io_write_en,
   input  logic                  io_read_en,
   input  logic [31:0]           io_address,
   input  logic [31:0]           io_write_data,
   output logic [31:0]           io_read_data,
   output logic                  overflow_irq
);

   localparam int NC = NUM_COUNTERS;

   logic [31:0]   off;
   logic [27:0]   slot;
   logic [3:0]    regsel;
   logic          mapped;
   logic          glob;

   logic [NC-1:0] sel_we, lo_we, hi_we, lo_re, wrap_vec;
   logic [31:0]   sel_rd    [NC];
   logic [31:0]   lo_rd     [NC];
   logic [31:0]   hi_rd     [NC];

   logic          ctrl_q, ctrl_d;
   logic [NC-1:0] status_q, status_d;
   logic [NC-1:0] mask_q, mask_d;
   logic          irq_q, irq_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   rd_mux;

   // Only word-aligned offsets inside the counter slots plus three globals are mapped
   assign off    = io_address - 32'(BASE_ADDRESS);
   assign mapped = (io_address >= 32'(BASE_ADDRESS))
                && (off < 32'(16 * NC + 12))
                && (off[1:0] == 2'b00);
   assign slot   = off[31:4];
   assign regsel = off[3:0];
   assign glob   = mapped && (slot == 28'(NC));

   for (genvar i = 0; i < NC; i++) begin : g_slice
      logic here;
      assign here      = mapped && (slot == 28'(i));
      assign sel_we[i] = io_write_en && here && (regsel == PERF_SEL);
      assign lo_we[i]  = io_write_en && here && (regsel == PERF_COUNT_LO);
      assign hi_we[i]  = io_write_en && here && (regsel == PERF_COUNT_HI);
      assign lo_re[i]  = io_read_en  && here && (regsel == PERF_COUNT_LO);

      perf_counter_slice #(
         .NUM_EVENTS   (NUM_EVENTS),
         .COUNTER_WIDTH(COUNTER_WIDTH)
      ) u_slice (
         .clk          (clk),
         .reset        (reset),
         .perf_events_i(perf_events),
         .freeze_i     (ctrl_q),
         .sel_we_i     (sel_we[i]),
         .lo_we_i      (lo_we[i]),
         .hi_we_i      (hi_we[i]),
         .lo_re_i      (lo_re[i]),
         .wdata_i      (io_write_data),
         .sel_o        (sel_rd[i]),
         .count_lo_o   (lo_rd[i]),
         .shadow_o     (hi_rd[i]),
         .wrap_o       (wrap_vec[i])
      );
   end

   always_comb begin
      ctrl_d   = ctrl_q;
      status_d = status_q;
      mask_d   = mask_q;
      if (io_write_en && glob) begin
         case (regsel)
            PERF_CTRL:       ctrl_d   = io_write_data[0];
            PERF_OVF_STATUS: status_d = status_q & ~io_write_data[NC-1:0];
            PERF_OVF_MASK:   mask_d   = io_write_data[NC-1:0];
            default:         ;
         endcase
      end
      // OR-ing wraps after the clear makes a coincident wrap win over W1C
      status_d = status_d | wrap_vec;
      irq_d    = |(status_q & mask_q);
   end

   always_comb begin
      rd_mux = '0;
      if (glob) begin
         case (regsel)
            PERF_CTRL:       rd_mux = 32'(ctrl_q);
            PERF_OVF_STATUS: rd_mux = 32'(status_q);
            PERF_OVF_MASK:   rd_mux = 32'(mask_q);
            default:         rd_mux = '0;
         endcase
      end else if (mapped) begin
         for (int i = 0; i < NC; i++) begin
            if (slot == 28'(i)) begin
               case (regsel)
                  PERF_SEL:      rd_mux = sel_rd[i];
                  PERF_COUNT_LO: rd_mux = lo_rd[i];
                  PERF_COUNT_HI: rd_mux = hi_rd[i];
                  default:       rd_mux = '0;
               endcase
            end
         end
      end
      rdata_d = io_read_en ? rd_mux : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_q   <= 1'b0;
         status_q <= '0;
         mask_q   <= '0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         status_q <= status_d;
         mask_q   <= mask_d;
         irq_q    <= irq_d;
         rdata_q  <= rdata_d;
      end
   end

   assign io_read_data = rdata_q;
   assign overflow_irq = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
// ============================================================================
// tb_perf_counter_bank : directed stimulus with a queue-based read scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_perf_counter_bank;

   localparam int NE = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [NE-1:0] perf_events;
   logic          io_write_en;
   logic          io_read_en;
   logic [31:0]   io_address;
   logic [31:0]   io_write_data;
   logic [31:0]   io_read_data;
   logic          overflow_irq;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [31:0]   exp_q  [$];
   string         name_q [$];
   logic          rd_pend = 1'b0;

   perf_counter_bank #(
      .NUM_EVENTS   (NE),
      .NUM_COUNTERS (4),
      .COUNTER_WIDTH(48),
      .BASE_ADDRESS ('h130)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .perf_events  (perf_events),
      .io_write_en  (io_write_en),
      .io_read_en   (io_read_en),
      .io_address   (io_address),
      .io_write_data(io_write_data),
      .io_read_data (io_read_data),
      .overflow_irq (overflow_irq)
   );

   always #5 clk = ~clk;

   // Monitor: data of a read accepted at one edge is compared on the following falling edge
   always @(posedge clk) rd_pend <= io_read_en & reset;

   always @(negedge clk) begin
      if (rd_pend) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: got %h, no expected value queued", io_read_data);
         end else begin
            logic [31:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (io_read_data !== e) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h", nm, io_read_data, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
      n_tests++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, e);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      io_address    = a;
      io_write_data = d;
      io_write_en   = 1'b1;
      tick();
      io_write_en   = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
      io_address = a;
      io_read_en = 1'b1;
      exp_q.push_back(e);
      name_q.push_back(nm);
      tick();
      io_read_en = 1'b0;
   endtask

   task automatic ev(input logic [NE-1:0] v, input int n);
      perf_events = v;
      repeat (n) tick();
      perf_events = '0;
   endtask

   localparam logic [31:0] SEL0 = 32'h130, LO0 = 32'h134, HI0 = 32'h138;
   localparam logic [31:0] SEL1 = 32'h140, LO1 = 32'h144;
   localparam logic [31:0] CTRL = 32'h170, STAT = 32'h174, MASK = 32'h178;

   initial begin
      reset         = 1'b0;
      perf_events   = '0;
      io_write_en   = 1'b0;
      io_read_en    = 1'b0;
      io_address    = '0;
      io_write_data = '0;
      tick();
      tick();
      chk("reset_rdata", io_read_data, 32'h0);
      chk("reset_irq", 32'(overflow_irq), 32'h0);
      reset = 1'b1;
      tick();

      // Every mapped address reads zero after reset, as does the unmapped G+12
      for (int a = 'h130; a < 'h17C; a += 4) rd(32'(a), 32'h0, $sformatf("reset_reg_%0h", a));
      rd(32'h17C, 32'h0, "unmapped_g12");
      chk("reset_irq_after", 32'(overflow_irq), 32'h0);

      // Counter 0 counts only event 3
      wr(SEL0, 32'h8000_0003);
      ev(16'h000C, 10);
      ev(16'h0004, 3);
      rd(LO0, 32'd10, "count_ev3");
      rd(SEL0, 32'h8000_0003, "sel0_readback");

      // Wrap from all-ones: status, irq latency, W1C
      wr(MASK, 32'h1);
      wr(HI0, 32'h0000_FFFF);
      wr(LO0, 32'hFFFF_FFFE);
      rd(STAT, 32'h0, "stat_before_wrap");
      ev(16'h0008, 2);
      chk("irq_lag", 32'(overflow_irq), 32'h0);
      tick();
      chk("irq_set", 32'(overflow_irq), 32'h1);
      rd(STAT, 32'h1, "stat_wrap");
      rd(LO0, 32'h0, "lo_after_wrap");
      rd(HI0, 32'h0, "hi_after_wrap");
      wr(STAT, 32'h1);
      chk("irq_hold_after_w1c", 32'(overflow_irq), 32'h1);
      tick();
      chk("irq_clear", 32'(overflow_irq), 32'h0);
      rd(STAT, 32'h0, "stat_cleared");

      // All-ones write does not flag; wrap coinciding with W1C keeps the bit set
      wr(HI0, 32'h0000_FFFF);
      wr(LO0, 32'hFFFF_FFFF);
      rd(STAT, 32'h0, "stat_allones_write");
      perf_events = 16'h0008;
      wr(STAT, 32'h1);
      perf_events = '0;
      rd(STAT, 32'h1, "stat_set_wins");
      rd(LO0, 32'h0, "lo_set_wins");
      wr(STAT, 32'h1);
      rd(STAT, 32'h0, "stat_cleared2");

      // Coherent split read across a carry
      wr(HI0, 32'h0);
      wr(LO0, 32'hFFFF_FFFF);
      rd(LO0, 32'hFFFF_FFFF, "lo_pre_carry");
      ev(16'h0008, 1);
      rd(HI0, 32'h0, "hi_shadow_old");
      rd(LO0, 32'h0, "lo_post_carry");
      rd(HI0, 32'h1, "hi_post_carry");

      // Write beats a same-cycle increment
      perf_events = 16'h0008;
      wr(LO0, 32'd5);
      perf_events = '0;
      rd(LO0, 32'd5, "write_wins");
      rd(HI0, 32'h1, "hi_after_write");

      // Freeze, out-of-range index, resume
      wr(SEL1, 32'h8000_0014);
      wr(CTRL, 32'h1);
      ev(16'h0008, 20);
      rd(LO0, 32'd5, "frozen");
      rd(CTRL, 32'h1, "ctrl_readback");
      wr(CTRL, 32'h0);
      ev(16'hFFFF, 3);
      rd(LO0, 32'd8, "resumed");
      rd(LO1, 32'h0, "index_out_of_range");
      rd(SEL1, 32'h8000_0014, "sel1_readback");

      // Reset in the middle of counting
      perf_events = 16'h0008;
      tick();
      reset = 1'b0;
      tick();
      reset       = 1'b1;
      perf_events = '0;
      chk("midreset_rdata", io_read_data, 32'h0);
      chk("midreset_irq", 32'(overflow_irq), 32'h0);
      rd(LO0, 32'h0, "midreset_lo0");
      rd(HI0, 32'h0, "midreset_hi0");
      rd(SEL0, 32'h0, "midreset_sel0");
      rd(MASK, 32'h0, "midreset_mask");
      rd(CTRL, 32'h0, "midreset_ctrl");

      tick();
      tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised bank of programmable performance counters, successor to the fixed per-event counter scheme sized by CORE_PERF_EVENTS and L2_PERF_EVENTS.
- Any of NUM_EVENTS event lines can be routed to any of NUM_COUNTERS wide counters.
- Adds global freeze, overflow status with interrupt mask, and coherent split reads of wide counters.
- Sits on the non-cached I/O bus as a slave, alongside the other peripheral register blocks.

Parameters:
NUM_EVENTS, `TOTAL_PERF_EVENTS, number of event input lines (1..256).
NUM_COUNTERS, 4, number of programmable counters (1..16).
COUNTER_WIDTH, 48, counter width in bits (33..64).
BASE_ADDRESS, 'h130, byte address of the register block; must be 4-byte aligned.

Ports:
clk  in  1  clock.
reset  in  1  synchronous reset, active-low; sampled on rising clk.
perf_events  in  NUM_EVENTS  one-cycle event pulses; bit i is event i.
io_write_en  in  1  I/O bus write strobe.
io_read_en  in  1  I/O bus read strobe; mutually exclusive with io_write_en.
io_address  in  32  I/O byte address.
io_write_data  in  32  write data.
io_read_data  out  32  read data, valid the cycle after io_read_en.
overflow_irq  out  1  level interrupt: OR of (ovf_status & ovf_mask).

Behaviour:
Register map, offset from BASE_ADDRESS:
- Per counter i, stride 16:
  - +16i+0 SEL: bits[7:0] event index, bit31 enable.
  - +16i+4 COUNT_LO.
  - +16i+8 COUNT_HI: bits COUNTER_WIDTH-33..0, upper bits read 0.
  - +16i+12 reserved, reads 0.
- Globals at G = 16*NUM_COUNTERS:
  - G+0 CTRL: bit0 freeze.
  - G+4 OVF_STATUS: write-1-to-clear.
  - G+8 OVF_MASK.
- All other addresses: writes ignored; reads return 0 and do not disturb state.

Reset, while reset==0 at a clk edge:
- All counters, SEL, CTRL, OVF_STATUS, OVF_MASK and HI shadows = 0.
- io_read_data = 0; overflow_irq = 0.

Counting:
- Counter i increments by 1 in a cycle when SEL.enable=1, CTRL.freeze=0, SEL.index<NUM_EVENTS and perf_events[SEL.index]=1.
- Index >= NUM_EVENTS never counts.
- Visible on the following cycle.

Overflow and interrupt:
- Increment from all-ones wraps to 0 and sets OVF_STATUS[i] in the same edge.
- Status bits are sticky until W1C.
- If a wrap and a W1C of the same bit coincide, set wins and the bit stays 1.
- overflow_irq is registered: it reflects status/mask one cycle after either changes.

Writes:
- A COUNT_LO/HI write replaces only that half.
- A write in the same cycle as an increment wins; the increment is dropped and no overflow is flagged.
- A write whose value is all-ones does not set overflow.

Coherent read:
- Reading COUNT_LO latches counter[W-1:32] into HI shadow i in the same edge.
- A COUNT_HI read returns the shadow, not the live value.
- Reading HI without a prior LO read returns the last latched shadow (0 after reset).

Read timing:
- io_read_data is registered, one-cycle latency.
- It holds its value until the next io_read_en; it is not cleared between reads.

Freeze:
- freeze=1 stops all counting.
- Register writes still take effect while frozen.

Decomposition:
- Shared package (defines): perf register offset constants (PERF_SEL, PERF_COUNT_LO, PERF_COUNT_HI, PERF_CTRL, PERF_OVF_STATUS, PERF_OVF_MASK), perf_event_idx_t = logic[7:0], and a packed perf_sel_t {enable, reserved[22:0], event_idx}.
- One natural sub-module: perf_counter_slice, instantiated NUM_COUNTERS times. Each slice holds one counter, its SEL, its HI shadow, and its increment/wrap/write-priority logic, and outputs a wrap pulse.
- Top level holds address decode, CTRL/status/mask and the read mux.

Test Plan:
1. Reset, then read every mapped address -> all 0. Read an unmapped offset G+12 -> 0. overflow_irq=0.
2. SEL0 = 'h80000003, pulse perf_events[3] for 10 cycles, read COUNT_LO -> 10. Event 2 pulses meanwhile -> still 10.
3. Write COUNT_HI0 = 'hFFFF and COUNT_LO0 = 'hFFFFFFFE with mask=1, then pulse event 3 twice -> counter 0, OVF_STATUS = 1, overflow_irq=1 one cycle after status set. W1C -> irq drops 1 cycle after status clears.
4. Counter at 'h0_FFFFFFFF: read LO (gets 'hFFFFFFFF), one more event, read HI -> 0, the shadow from before the carry. A fresh LO/HI pair -> 0/1.
5. Write COUNT_LO = 5 in the same cycle as an enabled event -> reads 5.
6. CTRL.freeze=1 with events active for 20 cycles -> counts unchanged; freeze=0 resumes. Assert reset (0) mid-count -> all registers 0 next cycle.
